// File: rtl/decoder38_scan.sv
// Registered 3-to-8 decoder with active-low one-hot selects, 74x138-style enables,
// and an auto-scan mode that steps the address every SCAN_DIV cycles with leading blanking.
module decoder38_scan #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 2,
    parameter int DIV_W     = 16
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic [2:0] iData,
    input  logic       iG1,
    input  logic       iG2A_n,
    input  logic       iG2B_n,
    input  logic       iMode,
    output logic [7:0] oData,
    output logic [2:0] oAddr,
    output logic       oStep,
    output logic       oEO
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_e;

    localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_L  = DIV_W'(BLANK_CYC);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [2:0]       addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic             step_q, step_d;
    logic             eo_q, eo_d;
    logic             en;

    assign en = iG1 & ~iG2A_n & ~iG2B_n;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= 3'd0;
            data_q  <= 8'hFF;
            step_q  <= 1'b0;
            eo_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            step_q  <= step_d;
            eo_q    <= eo_d;
        end
    end

    // Outputs are computed from the next-cycle cnt/addr so they land in the same register stage.
    always_comb begin
        state_d = IDLE;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = 8'hFF;
        step_d  = 1'b0;
        eo_d    = 1'b1;
        if (!en) begin
            state_d = IDLE;
        end else if (!iMode) begin
            state_d = MANUAL;
            cnt_d   = '0;
            addr_d  = iData;
            data_d  = ~(8'h01 << iData);
            eo_d    = 1'b0;
        end else begin
            state_d = SCAN;
            if (state_q != SCAN) begin
                cnt_d  = '0;
                addr_d = 3'd0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                addr_d = addr_q + 3'd1;
                step_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            if (cnt_d >= BLANK_L) begin
                data_d = ~(8'h01 << addr_d);
                eo_d   = 1'b0;
            end
        end
    end

    assign oData = data_q;
    assign oAddr = addr_q;
    assign oStep = step_q;
    assign oEO   = eo_q;

endmodule
